// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline-control types and constants for the hazard control unit.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

    // A load in EX feeding an operand that the ID instruction really reads; x0 never matches.
    function automatic logic load_use_hit(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       mem_read,
        input logic       use1,
        input logic       use2
    );
        return mem_read && (rd != REG_ZERO) &&
               ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_chk.sv
// Property checker: a LOAD_STALL cycle never re-stalls and always returns to RUN.
module hazard_control_unit_chk
    import hazard_control_unit_pkg::*;
(
    input logic      clk,
    input logic      rst_n,
    input hz_state_t state,
    input logic      stall_id,
    input logic      stall_ex
);

    property p_no_second_stall;
        @(posedge clk) disable iff (!rst_n)
            (state == LOAD_STALL && !stall_ex) |-> !stall_id;
    endproperty

    property p_back_to_run;
        @(posedge clk) disable iff (!rst_n)
            (state == LOAD_STALL && !stall_ex) |=> (state == RUN);
    endproperty

    a_no_second_stall: assert property (p_no_second_stall);
    a_back_to_run:     assert property (p_back_to_run);

endmodule

// File: rtl/hazard_control_unit_wait_timer.sv
// Saturating data-memory wait counter with a sticky timeout flag.
module hazard_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_wait,
    output logic timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             err_r;

    // Count consecutive wait cycles, holding at the limit; any non-wait cycle clears.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!mem_wait) begin
            cnt_nxt_s = '0;
        end else if (cnt_r != LIMIT) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and error register; the error stays set until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            err_r <= err_r | (cnt_nxt_s == LIMIT);
        end
    end

    assign timeout_err = err_r;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-squash / memory-wait hazard control for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_addr_id,
    input  logic [4:0]        rs2_addr_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [4:0]        rd_addr_ex,
    input  logic              mem_read_en_ex,
    input  logic              branch_taken_ex,
    input  logic              dmem_req_mem,
    input  logic              dmem_ready_mem,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              stall_ex,
    output logic              bubble_wb,
    output logic [1:0]        hz_state,
    output logic              mem_timeout_err,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [PERF_W-1:0] perf_wait_cnt
);

    hz_state_t state_r;
    hz_state_t state_nxt_s;
    logic      mem_wait_s;
    logic      load_use_s;

    assign mem_wait_s = dmem_req_mem && !dmem_ready_mem;
    // In LOAD_STALL any match is stale (the bubble is in EX), so it is ignored.
    assign load_use_s = (state_r != LOAD_STALL) &&
                        load_use_hit(rd_addr_ex, rs1_addr_id, rs2_addr_id,
                                     mem_read_en_ex, rs1_used_id, rs2_used_id);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state selection by hazard priority: memory wait, branch, load-use.
    always_comb begin
        state_nxt_s = RUN;
        if (mem_wait_s) begin
            state_nxt_s = MEM_WAIT;
        end else if (branch_taken_ex) begin
            state_nxt_s = RUN;
        end else if (load_use_s) begin
            state_nxt_s = LOAD_STALL;
        end else begin
            state_nxt_s = RUN;
        end
    end

    // Pipeline-register controls, same-cycle, all low while reset is asserted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        stall_ex  = 1'b0;
        bubble_wb = 1'b0;
        if (!rst_n) begin
            stall_if = 1'b0;
        end else if (mem_wait_s) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            bubble_wb = 1'b1;
        end else if (branch_taken_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_use_s) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            stall_if = 1'b0;
        end
    end

    assign hz_state = state_r;

    hazard_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_wait    (mem_wait_s),
        .timeout_err (mem_timeout_err)
    );

    hazard_control_unit_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .state    (state_r),
        .stall_id (stall_id),
        .stall_ex (stall_ex)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_r;
    logic [PERF_W-1:0] flush_cnt_r;
    logic [PERF_W-1:0] wait_cnt_r;

    // Event counters: stall_id without stall_ex can only be a load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
            wait_cnt_r  <= '0;
        end else begin
            stall_cnt_r <= stall_cnt_r + PERF_W'(stall_id && !stall_ex);
            flush_cnt_r <= flush_cnt_r + PERF_W'(flush_id);
            wait_cnt_r  <= wait_cnt_r + PERF_W'(stall_ex);
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
    assign perf_wait_cnt  = wait_cnt_r;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
    assign perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios plus randomized
// stimulus checked against a cycle-level reference model of the hazard rules.
module tb_hazard_control_unit;

    localparam int TO = 3;
    localparam int PW = 16;
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b001100;
    localparam logic [5:0] C_MW   = 6'b110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mr, br, req, rdy;
    logic          stall_if, stall_id, flush_id, bubble_ex, stall_ex, bubble_wb;
    logic [1:0]    hz_state;
    logic          err;
    logic [PW-1:0] p_stall, p_flush, p_wait;
    logic [5:0]    ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {stall_if, stall_id, flush_id, bubble_ex, stall_ex, bubble_wb};

    hazard_control_unit #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_id(rs1), .rs2_addr_id(rs2),
        .rs1_used_id(u1), .rs2_used_id(u2),
        .rd_addr_ex(rd), .mem_read_en_ex(mr), .branch_taken_ex(br),
        .dmem_req_mem(req), .dmem_ready_mem(rdy),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .stall_ex(stall_ex), .bubble_wb(bubble_wb),
        .hz_state(hz_state), .mem_timeout_err(err),
        .perf_stall_cnt(p_stall), .perf_flush_cnt(p_flush), .perf_wait_cnt(p_wait)
    );

    task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic e1,
                          input logic e2, input logic [4:0] d, input logic m,
                          input logic b, input logic q, input logic r);
        rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = m; br = b; req = q; rdy = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_NONE); end
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", hz_state); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++;
        if ({p_stall, p_flush, p_wait} !== '0) begin
            errors++; $display("FAIL reset_perf got %0h/%0h/%0h exp 0", p_stall, p_flush, p_wait);
        end
        #1;
        do_reset();
    endtask

    task automatic test_load_use();
        set_in(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_ctl got %b exp %b", ctl, C_LU); end
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL lu_state0 got %0d exp 0", hz_state); end
        next_cycle();
        #1;
        checks++;
        if (ctl !== C_NONE) begin errors++; $display("FAIL lu_second_stall got %b exp %b", ctl, C_NONE); end
        checks++;
        if (hz_state !== 2'd1) begin errors++; $display("FAIL lu_state1 got %0d exp 1", hz_state); end
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL lu_state2 got %0d exp 0", hz_state); end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                1:       set_in(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
                default: set_in(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            #1;
            checks++;
            if (ctl !== C_NONE) begin errors++; $display("FAIL nohz_ctl[%0d] got %b exp %b", i, ctl, C_NONE); end
            next_cycle();
            #1;
            checks++;
            if (hz_state !== 2'd0) begin errors++; $display("FAIL nohz_state[%0d] got %0d exp 0", i, hz_state); end
        end
        next_cycle();
    endtask

    task automatic test_branch_override();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL br_ctl got %b exp %b", ctl, C_BR); end
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL br_state got %0d exp 0", hz_state); end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        logic [PW-1:0] exp_wait;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, (k == 0), 1'b1, 1'b0);
            #1;
            checks++;
            if (ctl !== C_MW) begin errors++; $display("FAIL mw_ctl[%0d] got %b exp %b", k, ctl, C_MW); end
            checks++;
            if (hz_state !== ((k == 0) ? 2'd0 : 2'd2)) begin
                errors++; $display("FAIL mw_state[%0d] got %0d", k, hz_state);
            end
            next_cycle();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        exp_wait = PW'(4);
`else
        exp_wait = '0;
`endif
        checks++;
        if (ctl !== C_NONE || hz_state !== 2'd2) begin
            errors++; $display("FAIL mw_release got %b/%0d exp %b/2", ctl, hz_state, C_NONE);
        end
        checks++;
        if (p_wait !== exp_wait) begin errors++; $display("FAIL mw_perf got %0d exp %0d", p_wait, exp_wait); end
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (hz_state !== 2'd0) begin errors++; $display("FAIL mw_run got %0d exp 0", hz_state); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (err !== (k >= TO)) begin errors++; $display("FAIL to_err[%0d] got %b exp %b", k, err, (k >= TO)); end
            next_cycle();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (err !== 1'b1 || hz_state !== 2'd0) begin
            errors++; $display("FAIL to_sticky got %b/%0d exp 1/0", err, hz_state);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== C_NONE || hz_state !== 2'd0 || err !== 1'b0) begin
            errors++; $display("FAIL midrst got %b/%0d/%b exp %b/0/0", ctl, hz_state, err, C_NONE);
        end
        checks++;
        if ({p_stall, p_flush, p_wait} !== '0) begin
            errors++; $display("FAIL midrst_perf got %0h/%0h/%0h exp 0", p_stall, p_flush, p_wait);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        next_cycle();
        set_in(5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL midrst_after got %b exp %b", ctl, C_LU); end
        next_cycle();
    endtask

    task automatic test_random();
        int            m_state;
        int            m_run;
        logic          m_err;
        logic [PW-1:0] m_stall, m_flush, m_wait;
        logic [PW-1:0] e_stall, e_flush, e_wait;
        logic          mw, hit;
        logic [5:0]    e_ctl;
        do_reset();
        m_state = 0; m_run = 0; m_err = 1'b0;
        m_stall = '0; m_flush = '0; m_wait = '0;
        for (int n = 0; n < 400; n++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
            #1;
            mw  = req && !rdy;
            hit = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            if (mw)                          e_ctl = C_MW;
            else if (br)                     e_ctl = C_BR;
            else if (hit && m_state != 1)    e_ctl = C_LU;
            else                             e_ctl = C_NONE;
`ifdef HAZARD_PERF_CNT_EN
            e_stall = m_stall; e_flush = m_flush; e_wait = m_wait;
`else
            e_stall = '0; e_flush = '0; e_wait = '0;
`endif
            checks++;
            if (ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl[%0d] got %b exp %b", n, ctl, e_ctl); end
            checks++;
            if (hz_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d] got %0d exp %0d", n, hz_state, m_state); end
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", n, err, m_err); end
            checks++;
            if (p_stall !== e_stall || p_flush !== e_flush || p_wait !== e_wait) begin
                errors++;
                $display("FAIL rnd_perf[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d",
                         n, p_stall, p_flush, p_wait, e_stall, e_flush, e_wait);
            end
            if (e_ctl == C_LU) m_stall++;
            if (e_ctl == C_BR) m_flush++;
            if (mw) m_wait++;
            m_run = mw ? ((m_run < TO) ? m_run + 1 : TO) : 0;
            if (m_run == TO) m_err = 1'b1;
            m_state = mw ? 2 : (e_ctl == C_LU ? 1 : 0);
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_override();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side counterpart to the EX-stage forwarding logic: resolves the hazards that forwarding cannot cover.
- Detects load-use hazards in ID, squashes on taken branches resolved in EX, and freezes the whole pipeline while data memory is not ready.
- Drives stall/flush/bubble enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core.
- Small FSM plus wait-timeout counter; optional performance counters.

Parameters:
- MEM_TIMEOUT, 255, max consecutive memory-wait cycles before the sticky error is raised (1..65535).
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active low
- rs1_addr_id  in  5  rs1 of the instruction in ID
- rs2_addr_id  in  5  rs2 of the instruction in ID
- rs1_used_id  in  1  instruction in ID reads rs1
- rs2_used_id  in  1  instruction in ID reads rs2
- rd_addr_ex  in  5  rd of the instruction in EX
- mem_read_en_ex  in  1  instruction in EX is a load
- branch_taken_ex  in  1  branch/jump in EX redirects PC
- dmem_req_mem  in  1  instruction in MEM accesses data memory
- dmem_ready_mem  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- flush_id  out  1  clear IF/ID to NOP
- bubble_ex  out  1  load NOP into ID/EX
- stall_ex  out  1  hold ID/EX and EX/MEM
- bubble_wb  out  1  load NOP into MEM/WB
- hz_state  out  2  current FSM state
- mem_timeout_err  out  1  sticky timeout flag
- perf_stall_cnt, perf_flush_cnt, perf_wait_cnt  out  PERF_W each  performance counters

Behaviour:
- Reset (async, rst_n=0): state RUN, wait counter 0, mem_timeout_err 0, perf counters 0. All outputs 0 during reset.
- States (hz_state encoding): RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle. The FSM is registered.
- mem_wait = dmem_req_mem && !dmem_ready_mem. This has highest priority.
  - Asserts stall_if, stall_id, stall_ex and bubble_wb.
  - flush_id and bubble_ex are forced to 0.
  - Next state is MEM_WAIT, and the wait counter increments, saturating at MEM_TIMEOUT.
- MEM_WAIT -> RUN in the cycle after mem_wait deasserts; the wait counter then clears.
- When the wait counter reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until reset. The stall continues; no recovery is attempted.
- Branch, second priority: branch_taken_ex && !mem_wait asserts flush_id and bubble_ex.
  - stall_if and stall_id are 0, so the redirect PC loads.
  - It overrides a concurrent load-use: the dependent instruction is squashed, and the next state is RUN.
  - A branch coinciding with mem_wait is held in the frozen EX stage and is acted on in the first non-waiting cycle.
- Load-use, third priority: mem_read_en_ex && rd_addr_ex!=0 && ((rs1_used_id && rs1_addr_id==rd_addr_ex) || (rs2_used_id && rs2_addr_id==rd_addr_ex)).
  - Asserts stall_if, stall_id and bubble_ex for exactly one cycle; next state is LOAD_STALL.
- In LOAD_STALL the load has moved to MEM and the bubble sits in EX, so the hazard term evaluates false. No second stall is issued, and the FSM returns to RUN.
- If a stale match reappears in LOAD_STALL, the FSM still returns to RUN without stalling; this is checked by an assertion.
- x0 never causes a hazard. An unused operand (used flag 0) never causes a hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: three free-running PERF_W counters that wrap on overflow.
  - perf_stall_cnt increments on each load-use stall cycle.
  - perf_flush_cnt increments on each branch flush cycle.
  - perf_wait_cnt increments on each mem_wait cycle.
- Undefined: the ports remain and are tied to 0; no counter flops exist.

Decomposition:
- Shared pipeline package holds the hz_state_t enum (RUN, LOAD_STALL, MEM_WAIT), the REG_ZERO constant 5'd0, and the NOP instruction constant used by the bubble/flush paths.
- One natural sub-module, hazard_wait_timer: saturating wait counter plus sticky error, parameterised by MEM_TIMEOUT.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 with rs1_used=1 -> stall_if=stall_id=bubble_ex=1 for 1 cycle; hz_state 0->1->0; no second stall.
- Load to x0 in EX, ID reads x0 -> no stall. Load x7 in EX, ID rs2=x7 with rs2_used=0 -> no stall.
- branch_taken_ex=1 concurrent with load-use match -> flush_id=bubble_ex=1, stall_if=0, hz_state stays 0.
- dmem_req_mem=1 with ready low for 4 cycles -> stall_if/stall_id/stall_ex/bubble_wb high for 4 cycles; RUN one cycle after ready rises; perf_wait_cnt=4 when HAZARD_PERF_CNT_EN is defined.
- MEM_TIMEOUT=3, ready held low for 5 cycles -> mem_timeout_err rises on the 3rd wait cycle, stays 1 after ready returns, clears only on rst_n=0.
- rst_n asserted mid-MEM_WAIT -> all outputs 0 immediately (async), hz_state=0, counters 0; normal operation after release.
